// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions.
// Used by the SNG, the scaled SC adder and the stream counter.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD
  } sc_state_e;

  localparam int SC_LEN = 64;

  // x^8+x^6+x^5+x^4+1 as Fibonacci taps on bits 7,5,4,3
  localparam logic [7:0] SC_TAPS = 8'hB8;
  localparam logic [7:0] SC_SEED = 8'h01;

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[7-i];
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] x,
    input int unsigned n
  );
    logic [15:0] d;
    d = {x, x} << (n % 8);
    return d[15:8];
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR, period 255.
// A zero seed is swapped for the default so the state never locks up.
module sc_lfsr8
  import sc_pkg::*;
#(
  parameter logic [7:0] SEED = SC_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  localparam logic [7:0] INIT = (SEED == 8'h00) ? SC_SEED : SEED;

  logic [7:0] state_q;
  logic       fb;

  assign fb    = ^(state_q & SC_TAPS);
  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
    end else if (en) begin
      state_q <= {state_q[6:0], fb};
    end
  end

endmodule

// File: rtl/sc_sng_3.sv
// Three-channel LFSR-compare stochastic number generator.
// Produces LEN-bit unipolar streams A/B/C from 8-bit probabilities.
module sc_sng_3
  import sc_pkg::*;
#(
  parameter int         LEN  = SC_LEN,
  parameter logic [7:0] SEED = SC_SEED
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     va,
  input  logic [7:0]     vb,
  input  logic [7:0]     vc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] A,
  output logic [LEN-1:0] B,
  output logic [LEN-1:0] C
);

  localparam int CW = $clog2(LEN);

  sc_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     va_q, vb_q, vc_q;
  logic [LEN-1:0] a_q, b_q, c_q;
  logic [7:0]     lfsr;
  logic           gen;
  logic           last;

  assign gen       = (state_q == GEN);
  assign last      = &cnt_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;

  sc_lfsr8 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (gen),
    .state(lfsr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = GEN;
      GEN:     if (last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      if (in_ready && in_valid) begin
        va_q  <= va;
        vb_q  <= vb;
        vc_q  <= vc;
        cnt_q <= '0;
      end
      // Permuted LFSR views decorrelate the three channels
      if (gen) begin
        a_q[cnt_q] <= (lfsr <= va_q);
        b_q[cnt_q] <= (bitrev8(lfsr) <= vb_q);
        c_q[cnt_q] <= (rotl8(lfsr, 3) <= vc_q);
        cnt_q      <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sc_sng_3.sv
// Scoreboard bench for sc_sng_3.
// Golden LFSR-compare model runs continuously across blocks.
module tb_sc_sng_3;

  localparam int LEN = 64;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     va, vb, vc;
  logic           out_valid;
  logic           out_ready;
  logic [LEN-1:0] A, B, C;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [7:0] m_lfsr;
  exp_t q[$];

  sc_sng_3 #(
    .LEN (LEN),
    .SEED(8'h01)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .va       (va),
    .vb       (vb),
    .vc       (vc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A        (A),
    .B        (B),
    .C        (C)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, b, c);
    exp_t       e;
    logic [7:0] r;
    logic [7:0] t;
    e = '0;
    for (int i = 0; i < LEN; i++) begin
      for (int k = 0; k < 8; k++) r[k] = m_lfsr[7-k];
      t = {m_lfsr[4:0], m_lfsr[7:5]};
      e.a[i] = (m_lfsr <= a);
      e.b[i] = (r <= b);
      e.c[i] = (t <= c);
      m_lfsr = {m_lfsr[6:0],
                m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    return e;
  endfunction

  task automatic send(
    input  logic [7:0] a, b, c,
    input  bit         push,
    output int         acc
  );
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 4 * LEN) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    va = a;
    vb = b;
    vc = c;
    in_valid = 1'b1;
    acc = cyc;
    if (push) q.push_back(model(a, b, c));
    @(negedge clk);
    in_valid = 1'b0;
    va = 8'($urandom);
    vb = 8'($urandom);
    vc = 8'($urandom);
  endtask

  task automatic wait_ov(output int c);
    int k;
    k = 0;
    while (!out_valid && k < 4 * LEN) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic take(output exp_t got);
    exp_t e;
    got = {A, B, C};
    if (q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check("stream_a", got.a, e.a);
      check("stream_b", got.b, e.b);
      check("stream_c", got.c, e.c);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ov_drop", out_valid, 0);
    check("ir_rise", in_ready, 1);
  endtask

  task automatic in_range(input string tag, input logic [63:0] s);
    int n;
    n = $countones(s);
    check(tag, (n >= 20 && n <= 44), 1);
  endtask

  initial begin
    exp_t g, g1, g2, first;
    int   acc, ovc;
    bit   saw;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    va = '0;
    vb = '0;
    vc = '0;
    m_lfsr = 8'h01;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_a", A, 0);
    check("rst_b", B, 0);
    check("rst_c", C, 0);
    check("rst_lfsr", dut.lfsr, 8'h01);

    // extremes and latency
    send(8'd0, 8'd255, 8'd0, 1, acc);
    wait_ov(ovc);
    check("latency", 64'(ovc - acc), 64'(LEN + 1));
    take(g);
    check("zero_a", g.a, 64'h0);
    check("ones_b", g.b, 64'hFFFF_FFFF_FFFF_FFFF);
    check("zero_c", g.c, 64'h0);
    release_out();

    // mid-scale, decorrelated channels
    send(8'd128, 8'd128, 8'd128, 1, acc);
    wait_ov(ovc);
    take(g);
    in_range("pop_a", g.a);
    in_range("pop_b", g.b);
    in_range("pop_c", g.c);
    check("a_ne_b", (g.a != g.b), 1);
    check("b_ne_c", (g.b != g.c), 1);
    check("a_ne_c", (g.a != g.c), 1);
    release_out();

    // backpressure with ignored input
    send(8'd100, 8'd30, 8'd220, 1, acc);
    wait_ov(ovc);
    take(g);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      va = 8'd255;
      vb = 8'd255;
      vc = 8'd255;
      @(negedge clk);
      check("bp_ov", out_valid, 1);
      check("bp_ir", in_ready, 0);
      check("bp_a", A, g.a);
      check("bp_b", B, g.b);
      check("bp_c", C, g.c);
    end
    in_valid = 1'b0;
    release_out();
    repeat (3) @(negedge clk);
    check("bp_ignored", in_ready, 1);

    // consecutive blocks, continuous LFSR
    send(8'd128, 8'd77, 8'd190, 1, acc);
    wait_ov(ovc);
    take(g1);
    release_out();
    send(8'd128, 8'd77, 8'd190, 1, acc);
    wait_ov(ovc);
    take(g2);
    release_out();
    check("blk_differ", (g1.a != g2.a), 1);

    // abort mid-GEN and reload
    rst = 1'b1;
    m_lfsr = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    send(8'd90, 8'd160, 8'd40, 1, acc);
    wait_ov(ovc);
    take(first);
    release_out();
    send(8'd90, 8'd160, 8'd40, 0, acc);
    saw = 1'b0;
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      saw |= out_valid;
    end
    rst = 1'b1;
    #1;
    check("abort_ir", in_ready, 1);
    check("abort_ov", out_valid, 0);
    check("abort_lfsr", dut.lfsr, 8'h01);
    check("abort_a", A, 0);
    m_lfsr = 8'h01;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LEN + 10; i++) begin
      @(negedge clk);
      saw |= out_valid;
    end
    check("abort_no_ov", saw, 0);
    send(8'd90, 8'd160, 8'd40, 1, acc);
    wait_ov(ovc);
    take(g);
    release_out();
    check("reload_a", g.a, first.a);
    check("reload_b", g.b, first.b);
    check("reload_c", g.c, first.c);
    check("sb_drained", 64'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
